// File: rtl/rom_line_pkg.sv
`default_nettype none
// ==========================================================================
// rom_line_pkg : state encodings and sizing helpers for rom_line_arbiter
// Revision 1.0 : initial release
// ==========================================================================
package rom_line_pkg;

  typedef enum logic [1:0] {
    CH_IDLE     = 2'd0,
    CH_WAIT_MEM = 2'd1,
    CH_RESP     = 2'd2
  } ch_state_t;

  typedef enum logic [0:0] {
    M_IDLE = 1'b0,
    M_BUSY = 1'b1
  } mem_state_t;

  // Byte-offset bits inside one memory line of dw bits.
  function automatic int ob_bits(input int dw);
    return $clog2(dw / 8);
  endfunction

  function automatic int ptr_bits(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rom_line_rr_arbiter.sv
`default_nettype none
// ==========================================================================
// rom_line_rr_arbiter : picks the first waiting channel at or after rr_ptr
// Revision 1.0 : initial release
// ==========================================================================
module rom_line_rr_arbiter
  import rom_line_pkg::*;
#(
  parameter int NCH = 2
) (
  input  logic [NCH-1:0]           waiting,
  input  logic [ptr_bits(NCH)-1:0] rr_ptr,
  output logic [NCH-1:0]           grant,
  output logic                     grant_valid
);

  int idx;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = (int'(rr_ptr) + k) % NCH;
      if (!grant_valid && waiting[idx]) begin
        grant[idx]  = 1'b1;
        grant_valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rom_line_arbiter.sv
`default_nettype none
// ==========================================================================
// rom_line_arbiter : per-channel one-line byte caches sharing one line port
// Revision 1.0 : initial release
// ==========================================================================
module rom_line_arbiter
  import rom_line_pkg::*;
#(
  parameter int NCH = 2,
  parameter int AW  = 18,
  parameter int DW  = 64
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic                      inv,
  input  logic [NCH-1:0]            ch_req,
  input  logic [NCH*AW-1:0]         ch_addr,
  output logic [NCH-1:0]            ch_rdy,
  output logic [NCH*8-1:0]          ch_data,
  output logic                      mem_req,
  output logic [AW-ob_bits(DW)-1:0] mem_addr,
  input  logic                      mem_ready,
  input  logic [DW-1:0]             mem_data
);

  localparam int OB = ob_bits(DW);
  localparam int TW = AW - OB;
  localparam int PW = ptr_bits(NCH);

  ch_state_t      ch_st   [NCH];
  mem_state_t     mem_st;
  logic [NCH-1:0] valid;
  logic [TW-1:0]  tag     [NCH];
  logic [DW-1:0]  line    [NCH];
  logic [TW-1:0]  req_tag [NCH];
  logic [OB-1:0]  req_off [NCH];
  logic [7:0]     data_q  [NCH];
  logic [PW-1:0]  rr_ptr;
  logic           inv_pend;

  logic [TW-1:0]  in_tag [NCH];
  logic [OB-1:0]  in_off [NCH];
  logic [NCH-1:0] waiting;
  logic [NCH-1:0] grant;
  logic [NCH-1:0] fill;
  logic [NCH-1:0] hit;
  logic           grant_valid;
  logic [TW-1:0]  grant_tag;
  logic [PW-1:0]  grant_nxt;
  logic           fill_valid;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign in_tag[gi]          = ch_addr[gi*AW+OB +: TW];
    assign in_off[gi]          = ch_addr[gi*AW +: OB];
    assign waiting[gi]         = (ch_st[gi] == CH_WAIT_MEM);
    assign hit[gi]             = valid[gi] && !inv && (tag[gi] == in_tag[gi]);
    // Every waiter on the returned line is filled, not only the granted one.
    assign fill[gi]            = (mem_st == M_BUSY) && mem_ready && waiting[gi] &&
                                 (req_tag[gi] == mem_addr);
    assign ch_rdy[gi]          = (ch_st[gi] == CH_RESP);
    assign ch_data[gi*8 +: 8]  = data_q[gi];
  end

  rom_line_rr_arbiter #(
    .NCH (NCH)
  ) u_rr (
    .waiting     (waiting),
    .rr_ptr      (rr_ptr),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  always_comb begin
    grant_tag = '0;
    grant_nxt = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant[i]) begin
        grant_tag = req_tag[i];
        grant_nxt = (i == NCH - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  // A flush seen while the line was in flight makes the returned data
  // deliverable but not cacheable.
  assign fill_valid = !(inv || inv_pend);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mem_st   <= M_IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      rr_ptr   <= '0;
      inv_pend <= 1'b0;
      valid    <= '0;
      for (int i = 0; i < NCH; i++) begin
        ch_st[i]  <= CH_IDLE;
        data_q[i] <= '0;
      end
    end else begin
      case (mem_st)
        M_IDLE: begin
          if (grant_valid) begin
            mem_st   <= M_BUSY;
            mem_req  <= 1'b1;
            mem_addr <= grant_tag;
            rr_ptr   <= grant_nxt;
            inv_pend <= 1'b0;
          end
        end
        M_BUSY: begin
          if (inv) inv_pend <= 1'b1;
          if (mem_ready) begin
            mem_st  <= M_IDLE;
            mem_req <= 1'b0;
          end
        end
        default: mem_st <= M_IDLE;
      endcase

      for (int i = 0; i < NCH; i++) begin
        if (inv) valid[i] <= 1'b0;
        case (ch_st[i])
          CH_IDLE: begin
            if (ch_req[i]) begin
              req_tag[i] <= in_tag[i];
              req_off[i] <= in_off[i];
              if (hit[i]) begin
                data_q[i] <= line[i][{in_off[i], 3'b000} +: 8];
                ch_st[i]  <= CH_RESP;
              end else begin
                ch_st[i]  <= CH_WAIT_MEM;
              end
            end
          end
          CH_WAIT_MEM: begin
            if (fill[i]) begin
              line[i]   <= mem_data;
              tag[i]    <= req_tag[i];
              valid[i]  <= fill_valid;
              data_q[i] <= mem_data[{req_off[i], 3'b000} +: 8];
              ch_st[i]  <= CH_RESP;
            end
          end
          default: ch_st[i] <= CH_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rom_line_arbiter.sv
`default_nettype none
// ==========================================================================
// tb_rom_line_arbiter : directed and random checks against a ROM/cache model
// Revision 1.0 : initial release
// ==========================================================================
module tb_rom_line_arbiter;

  localparam int NCH = 2;
  localparam int AW  = 18;
  localparam int DW  = 64;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic              inv;
  logic [NCH-1:0]    ch_req;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH-1:0]    ch_rdy;
  logic [NCH*8-1:0]  ch_data;
  logic              mem_req;
  logic [AW-4:0]     mem_addr;
  logic              mem_ready;
  logic [DW-1:0]     mem_data;

  logic              auto_mem;
  logic              a_ready = 1'b0;
  logic [DW-1:0]     a_data  = '0;
  logic              man_ready;
  logic [DW-1:0]     man_data;

  logic              b_inv;
  logic              b_req;
  logic [AW-1:0]     b_addr;
  logic              b_rdy;
  logic [7:0]        b_data;
  logic              b_mem_req;
  logic [AW-5:0]     b_mem_addr;
  logic              b_ready;
  logic [127:0]      b_mem_data;
  logic [127:0]      wline;

  always #5 clk_sys = ~clk_sys;

  assign mem_ready = auto_mem ? a_ready : man_ready;
  assign mem_data  = auto_mem ? a_data  : man_data;

  rom_line_arbiter #(.NCH(NCH), .AW(AW), .DW(DW)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .inv       (inv),
    .ch_req    (ch_req),
    .ch_addr   (ch_addr),
    .ch_rdy    (ch_rdy),
    .ch_data   (ch_data),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ready (mem_ready),
    .mem_data  (mem_data)
  );

  rom_line_arbiter #(.NCH(1), .AW(AW), .DW(128)) dut_w (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .inv       (b_inv),
    .ch_req    (b_req),
    .ch_addr   (b_addr),
    .ch_rdy    (b_rdy),
    .ch_data   (b_data),
    .mem_req   (b_mem_req),
    .mem_addr  (b_mem_addr),
    .mem_ready (b_ready),
    .mem_data  (b_mem_data)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // ROM image: line 2 is fixed, every other line is a hash of its address.
  function automatic logic [63:0] line_fn(input int unsigned la);
    logic [31:0] h;
    if (la == 32'd2) return 64'h8877665544332211;
    h = la * 32'h9E3779B1;
    return {h, ~h ^ {la[15:0], la[15:0]}};
  endfunction

  function automatic logic [7:0] exp_byte(input int unsigned addr);
    logic [63:0] l;
    int          off;
    l   = line_fn(addr >> 3);
    off = int'(addr & 32'd7);
    return l[off*8 +: 8];
  endfunction

  // Memory responder with random 0..4 cycle latency.
  int cnt = 0;
  always @(negedge clk_sys) begin
    if (a_ready) begin
      a_ready = 1'b0;
      cnt     = int'($urandom_range(0, 4));
    end else if (mem_req) begin
      if (cnt == 0) begin
        a_ready = 1'b1;
        a_data  = line_fn(32'(mem_addr));
      end else begin
        cnt--;
      end
    end else begin
      cnt = int'($urandom_range(0, 4));
    end
  end

  // Transaction monitor: logs each line request and checks it stays put.
  logic        prev_req = 1'b0;
  int          txn_cnt  = 0;
  int unsigned txn_log[$];
  always @(negedge clk_sys) begin
    if (mem_req && !prev_req) begin
      txn_cnt++;
      txn_log.push_back(32'(mem_addr));
    end else if (mem_req && prev_req && txn_log.size() > 0) begin
      chk("mem_addr_stable", 128'(mem_addr), 128'(txn_log[$]));
    end
    prev_req = mem_req;
  end

  // Request scripts and cache model.
  int unsigned aq [NCH][$];
  int unsigned dq [NCH][$];
  bit          pend    [NCH];
  int          lat     [NCH];
  int unsigned cur     [NCH];
  bit          exp_hit [NCH];
  int          rdy_cyc [NCH];
  bit          mvalid  [NCH];
  int unsigned mtag    [NCH];
  bit          poison  [NCH];
  bit          inv_when_busy = 1'b0;
  int          cyc = 0;

  task automatic run_engine(input int max_cyc);
    int n;
    bit busy;
    n    = 0;
    busy = 1'b1;
    for (int c = 0; c < NCH; c++) pend[c] = 1'b0;
    while (busy && n < max_cyc) begin
      @(negedge clk_sys);
      n++;
      cyc++;
      inv = 1'b0;
      if (inv_when_busy && mem_req) begin
        inv           = 1'b1;
        inv_when_busy = 1'b0;
        for (int c = 0; c < NCH; c++) begin
          mvalid[c] = 1'b0;
          if (pend[c]) poison[c] = 1'b1;
        end
      end
      busy = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        if (pend[c]) begin
          if (ch_rdy[c]) begin
            chk($sformatf("ch%0d_data", c), 128'(ch_data[c*8 +: 8]), 128'(exp_byte(cur[c])));
            if (exp_hit[c]) chk($sformatf("ch%0d_hit_latency", c), 128'(lat[c] + 1), 128'(1));
            else            chk($sformatf("ch%0d_miss_went_to_mem", c), 128'((lat[c] + 1) > 1), 128'(1));
            pend[c]    = 1'b0;
            ch_req[c]  = 1'b0;
            rdy_cyc[c] = cyc;
            mvalid[c]  = !poison[c];
            mtag[c]    = cur[c] >> 3;
            poison[c]  = 1'b0;
          end else begin
            lat[c]++;
            if (lat[c] > 60) begin
              chk($sformatf("ch%0d_timeout", c), 128'(lat[c]), 128'(60));
              pend[c]   = 1'b0;
              ch_req[c] = 1'b0;
            end
          end
        end else begin
          chk($sformatf("ch%0d_spurious_rdy", c), 128'(ch_rdy[c]), 128'(0));
          if (aq[c].size() > 0) begin
            if (dq[c][0] > 0) begin
              dq[c][0] = dq[c][0] - 1;
            end else begin
              cur[c] = aq[c].pop_front();
              void'(dq[c].pop_front());
              exp_hit[c] = mvalid[c] && (mtag[c] == (cur[c] >> 3));
              ch_addr[c*AW +: AW] = cur[c][AW-1:0];
              ch_req[c] = 1'b1;
              pend[c]   = 1'b1;
              lat[c]    = 0;
            end
          end
        end
        if (pend[c] || aq[c].size() > 0) busy = 1'b1;
      end
    end
    inv = 1'b0;
    chk("engine_done", 128'(busy), 128'(0));
  endtask

  task automatic push_req(input int c, input int unsigned addr, input int unsigned dly);
    aq[c].push_back(addr);
    dq[c].push_back(dly);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int base;
  int bidx;

  initial begin
    reset = 1'b1; inv = 1'b0; ch_req = '0; ch_addr = '0;
    auto_mem = 1'b1; man_ready = 1'b0; man_data = '0;
    b_inv = 1'b0; b_req = 1'b0; b_addr = '0; b_ready = 1'b0; b_mem_data = '0; wline = '0;
    for (int c = 0; c < NCH; c++) begin
      mvalid[c] = 1'b0; poison[c] = 1'b0; mtag[c] = 0; rdy_cyc[c] = 0;
    end
    repeat (3) @(negedge clk_sys);
    chk("rst_ch_rdy",   128'(ch_rdy),    128'(0));
    chk("rst_ch_data",  128'(ch_data),   128'(0));
    chk("rst_mem_req",  128'(mem_req),   128'(0));
    chk("rst_mem_addr", 128'(mem_addr),  128'(0));
    chk("rst_w_rdy",    128'(b_rdy),     128'(0));
    chk("rst_w_memreq", 128'(b_mem_req), 128'(0));
    reset = 1'b0;

    // Miss then hit on line 2.
    base = txn_cnt;
    push_req(0, 32'h13, 0);
    run_engine(200);
    chk("t1_miss_txns", 128'(txn_cnt - base), 128'(1));
    chk("t1_mem_addr",  128'(txn_log[$]),     128'(2));
    base = txn_cnt;
    push_req(0, 32'h17, 0);
    run_engine(200);
    chk("t1_hit_no_txn", 128'(txn_cnt - base), 128'(0));

    // Coalescing on line 0x40.
    base = txn_cnt;
    push_req(0, 32'h201, 0);
    push_req(1, 32'h206, 0);
    run_engine(200);
    chk("t2_one_txn",    128'(txn_cnt - base), 128'(1));
    chk("t2_same_cycle", 128'(rdy_cyc[0]),     128'(rdy_cyc[1]));
    chk("t2_line",       128'(txn_log[$]),     128'(32'h40));

    // Fairness: ch0 misses back-to-back, ch1 once.
    bidx = txn_log.size();
    push_req(0, 32'h282, 0);
    push_req(0, 32'h295, 0);
    push_req(1, 32'h301, 1);
    run_engine(400);
    chk("t3_txns",   128'(txn_log.size() - bidx), 128'(3));
    chk("t3_grant0", 128'(txn_log[bidx]),         128'(32'h50));
    chk("t3_grant1", 128'(txn_log[bidx+1]),       128'(32'h60));
    chk("t3_grant2", 128'(txn_log[bidx+2]),       128'(32'h52));

    // Flush between fill and re-read.
    push_req(0, 32'h10, 0);
    run_engine(200);
    @(negedge clk_sys); inv = 1'b1;
    for (int c = 0; c < NCH; c++) mvalid[c] = 1'b0;
    @(negedge clk_sys); inv = 1'b0;
    base = txn_cnt;
    push_req(0, 32'h10, 0);
    run_engine(200);
    chk("t4_reread_txn", 128'(txn_cnt - base), 128'(1));

    // Flush while the line is in flight.
    inv_when_busy = 1'b1;
    push_req(0, 32'h3005, 0);
    run_engine(200);
    chk("t5_inv_fired", 128'(inv_when_busy), 128'(0));
    base = txn_cnt;
    push_req(0, 32'h3002, 0);
    run_engine(200);
    chk("t5_reread_txn", 128'(txn_cnt - base), 128'(1));

    // Random traffic over a small line set to provoke hits and coalescing.
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < 40; k++) begin
        push_req(c, ((32'h100 + $urandom_range(0, 5)) << 3) | $urandom_range(0, 7),
                 $urandom_range(0, 3));
      end
    end
    run_engine(8000);

    // Wide-line instance: top byte of a 128-bit line, then a hit.
    @(negedge clk_sys);
    b_req = 1'b1; b_addr = 18'h0012F;
    for (int k = 0; k < 20 && !b_mem_req; k++) @(negedge clk_sys);
    chk("w_mem_req",  128'(b_mem_req),  128'(1));
    chk("w_mem_addr", 128'(b_mem_addr), 128'(14'h12));
    wline = {$urandom, $urandom, $urandom, $urandom};
    b_mem_data = wline; b_ready = 1'b1;
    @(negedge clk_sys);
    b_ready = 1'b0;
    chk("w_rdy",  128'(b_rdy),  128'(1));
    chk("w_data", 128'(b_data), 128'(wline[127:120]));
    b_req = 1'b0;
    @(negedge clk_sys);
    b_req = 1'b1; b_addr = 18'h00123;
    @(negedge clk_sys);
    chk("w_hit_rdy",   128'(b_rdy),     128'(1));
    chk("w_hit_data",  128'(b_data),    128'(wline[31:24]));
    chk("w_hit_nomem", 128'(b_mem_req), 128'(0));
    b_req = 1'b0;

    // Reset with a line request outstanding; late mem_ready must be ignored.
    auto_mem = 1'b0;
    @(negedge clk_sys);
    ch_req[0] = 1'b1; ch_addr[0 +: AW] = 18'h3800;
    for (int k = 0; k < 20 && !mem_req; k++) @(negedge clk_sys);
    chk("t6_mem_req_up", 128'(mem_req), 128'(1));
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0; ch_req = '0;
    chk("t6_mem_req_drop", 128'(mem_req), 128'(0));
    chk("t6_no_rdy",       128'(ch_rdy),  128'(0));
    repeat (2) @(negedge clk_sys);
    man_data = line_fn(32'h700); man_ready = 1'b1;
    @(negedge clk_sys);
    man_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t6_late_rdy",    128'(ch_rdy),  128'(0));
      chk("t6_late_memreq", 128'(mem_req), 128'(0));
      @(negedge clk_sys);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rom_line_arbiter.md
ROM_LINE_ARBITER -- requirements
Module: rom_line_arbiter

Interface
REQ-001 The block SHALL expose these parameters:
- NCH, 2, number of byte-read client channels (1..8).
- AW, 18, client byte-address width.
- DW, 64, memory line width in bits (power of two, 16..256).
REQ-002 The block SHALL use one clock and a synchronous, active-high reset, with these ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous active-high reset.
- inv  in  1  one-cycle pulse; invalidates all cached lines.
- ch_req  in  NCH  per-channel read request, level.
- ch_addr  in  NCH*AW  packed byte addresses; channel i at [i*AW +: AW].
- ch_rdy  out  NCH  per-channel one-cycle data-valid pulse.
- ch_data  out  NCH*8  packed read bytes; channel i at [i*8 +: 8].
- mem_req  out  1  memory line request, level.
- mem_addr  out  AW-OB  line address, where OB = log2(DW/8).
- mem_ready  in  1  one-cycle pulse; mem_data valid.
- mem_data  in  DW  returned line.

Function
REQ-003 Each channel SHALL hold one cache line with a valid bit, a tag (ch_addr[AW-1:OB]) and DW bits of data.
REQ-004 Byte selection SHALL be little-endian: byte k = line[8k+7:8k], where k = ch_addr[OB-1:0].
REQ-005 Each channel FSM SHALL have three states: IDLE, WAIT_MEM and RESP.
REQ-006 In IDLE with ch_req=1, a valid tag match SHALL move the channel to RESP; otherwise the channel SHALL move to WAIT_MEM.
REQ-007 RESP SHALL last exactly one cycle: ch_rdy[i]=1, ch_data[i] = selected byte, then IDLE. Hit latency is therefore 1 cycle after the request is sampled.
REQ-008 ch_req is ignored in the RESP cycle. A request held high after ch_rdy SHALL be treated as a new request in the next cycle.
REQ-009 The requester SHALL hold ch_addr stable while ch_req is high until ch_rdy. The block samples ch_addr in IDLE and on fill.
REQ-010 The memory FSM SHALL have two states: M_IDLE and M_BUSY.
REQ-011 In M_IDLE, if any channel is in WAIT_MEM, the block SHALL grant the first waiting channel at or after rr_ptr (modulo NCH). It SHALL then drive mem_req=1 and mem_addr = that channel's tag from the next cycle, enter M_BUSY, and set rr_ptr = grant+1 mod NCH.
REQ-012 mem_req and mem_addr SHALL stay stable in M_BUSY until mem_ready, then deassert in the following cycle (M_IDLE).
REQ-013 On mem_ready, the granted channel SHALL store mem_data and its tag, set valid, and enter RESP in the next cycle.
REQ-014 Coalescing: on mem_ready, every other channel in WAIT_MEM with an equal line address SHALL also be filled and enter RESP in the same cycle.
REQ-015 mem_ready in M_IDLE SHALL be ignored.
REQ-016 inv SHALL clear all valid bits. If inv and a lookup coincide in the same cycle, inv wins and the lookup is a miss.
REQ-017 If inv occurs during M_BUSY or coincides with mem_ready:
- filled channels SHALL still get ch_rdy with correct data;
- their valid bits SHALL remain 0.
REQ-018 A new miss may enter WAIT_MEM while M_BUSY; it SHALL be served in a later grant with no loss.
REQ-019 With continuous contention, no channel SHALL wait more than NCH memory transactions for a grant.

Reset
REQ-020 After reset, the block SHALL be in this state:
- outputs: ch_rdy=0, ch_data=0, mem_req=0, mem_addr=0;
- internal state: all valid=0, rr_ptr=0, channels IDLE, memory M_IDLE.
REQ-021 Reset mid-transaction SHALL drop mem_req in the next cycle, with no ch_rdy for aborted requests. A late mem_ready is ignored per REQ-015.

Structure
REQ-022 Package rom_line_pkg SHALL hold the channel/memory state enums and a clog2-based OB helper.
REQ-023 Round-robin grant logic SHALL be one sub-module, rom_line_rr_arbiter (NCH parameter; waiting vector and rr_ptr in; grant one-hot and valid out).

Verification
REQ-024 Miss then hit (NCH=2, DW=64): ch0 addr 0x00013 -> mem_addr 0x0002. mem_ready with mem_data 0x8877665544332211 -> ch_rdy[0] next cycle, data 0x44. Then addr 0x00017 -> ch_rdy 1 cycle later, data 0x88, no mem_req.
REQ-025 Fairness: ch0 issues back-to-back misses on distinct lines while ch1 misses once -> grants go 0,1,0. ch1 is served no later than the second memory transaction.
REQ-026 Coalescing: ch0 and ch1 miss line 0x0040 in the same cycle -> exactly one mem_req. Both ch_rdy pulse in the same cycle with their own bytes.
REQ-027 Flush:
- fill line 0x0002, pulse inv, re-read 0x00010 -> new mem_req;
- inv pulsed during M_BUSY -> requester still gets data, and an immediate same-line re-read misses.
REQ-028 Reset with mem_req high -> mem_req=0 next cycle, no ch_rdy. A mem_ready 3 cycles later causes no output change.
REQ-029 DW=128 variant: addr low nibble 0xF -> ch_data = mem_data[127:120]. mem_addr = addr[AW-1:4].
